resta_display: RTL and testbench

// - Downstream stage of the subtractor: consumes its magnitude R and sign Neg.
// - Captures a result on a load strobe and converts it to BCD with a sequential

---
 rtl/resta_display.sv | 175 +++++++++++++++++
 tb/tb_resta_display.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/resta_display.sv
// ============================================================================
// Module   : resta_display
// Purpose  : Converts the subtractor's magnitude/sign to BCD (double dabble)
//            and drives a multiplexed active-low 7-segment display.
// Revision : 1.0
// ============================================================================
`default_nettype none

module resta_display #(
    parameter int N           = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [N-1:0]      R,
    input  logic              Neg,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [DIGITS:0]   an
);

    localparam int BW = 4 * DIGITS;
    localparam int AW = DIGITS + 1;
    localparam int CW = $clog2(N + 1);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS + 1);

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_MINUS = 7'b0111111;
    localparam logic [6:0] c_SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic [N-1:0]    r_shift;
    logic [BW-1:0]   r_bcd;
    logic [CW-1:0]   r_cnt;
    logic            r_sign_l;
    logic            r_nz_l;
    logic [BW-1:0]   r_shown_bcd;
    logic            r_shown_neg;

    logic [RW-1:0]   r_refresh;
    logic [IW-1:0]   r_idx;
    logic [AW-1:0]   r_an;
    logic [6:0]      r_seg;

    logic [BW-1:0]   w_bcd_adj;
    logic [IW-1:0]   w_next_idx;
    logic [3:0]      w_digit;
    logic            w_hi_zero;
    logic [6:0]      w_seg_next;
    logic [AW-1:0]   w_an_next;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction applied to every nibble before each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    // Shown digits/sign change only in DONE, so the display never sees a partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_shift     <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_sign_l    <= 1'b0;
            r_nz_l      <= 1'b0;
            r_shown_bcd <= '0;
            r_shown_neg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shift  <= R;
                        r_sign_l <= Neg;
                        r_nz_l   <= |R;
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    {r_bcd, r_shift} <= {w_bcd_adj[BW-2:0], r_shift, 1'b0};
                    r_cnt            <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1))
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_shown_bcd <= r_bcd;
                    r_shown_neg <= r_sign_l & r_nz_l;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_next_idx = (r_idx == IW'(DIGITS)) ? '0 : r_idx + IW'(1);
    assign w_an_next  = ~(AW'(1) << w_next_idx);

    // Leading-zero blanking: a digit is blank when it and every higher digit are zero
    always_comb begin
        w_digit   = 4'd0;
        w_hi_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == w_next_idx)
                w_digit = r_shown_bcd[4*k +: 4];
            if ((IW'(k) >= w_next_idx) && (r_shown_bcd[4*k +: 4] != 4'd0))
                w_hi_zero = 1'b0;
        end
        if (w_next_idx == IW'(DIGITS))
            w_seg_next = r_shown_neg ? c_SEG_MINUS : c_SEG_BLANK;
        else if ((w_next_idx != '0) && w_hi_zero)
            w_seg_next = c_SEG_BLANK;
        else
            w_seg_next = seg7(w_digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_an      <= ~AW'(1);
            r_seg     <= c_SEG_ZERO;
        end else if (r_refresh == RW'(REFRESH_DIV - 1)) begin
            r_refresh <= '0;
            r_idx     <= w_next_idx;
            r_an      <= w_an_next;
            r_seg     <= w_seg_next;
        end else begin
            r_refresh <= r_refresh + RW'(1);
        end
    end

    assign busy = r_busy;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule

`default_nettype wire

// File: tb/tb_resta_display.sv
// ============================================================================
// Module   : tb_resta_display
// Purpose  : Scoreboard-driven bench for resta_display (N=4, DIGITS=2, REFRESH_DIV=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_resta_display;

    localparam int c_N   = 4;
    localparam int c_DIG = 2;
    localparam int c_DIV = 2;

    localparam logic [6:0] c_BLANK = 7'b1111111;
    localparam logic [6:0] c_MINUS = 7'b0111111;

    logic             clk;
    logic             rst;
    logic             load;
    logic [c_N-1:0]   R;
    logic             Neg;
    logic             busy;
    logic [6:0]       seg;
    logic [c_DIG:0]   an;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] sgn;
        logic [6:0] tens;
        logic [6:0] units;
    } frame_t;

    frame_t exp_q[$];

    resta_display #(
        .N(c_N),
        .DIGITS(c_DIG),
        .REFRESH_DIV(c_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .R(R),
        .Neg(Neg),
        .busy(busy),
        .seg(seg),
        .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] code7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic frame_t model(input int r, input bit neg);
        frame_t f;
        f.sgn   = (neg && r != 0) ? c_MINUS : c_BLANK;
        f.tens  = (r / 10 == 0) ? c_BLANK : code7(r / 10);
        f.units = code7(r % 10);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int r, input bit neg);
        @(negedge clk);
        R    = c_N'(r);
        Neg  = neg;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        R    = ~c_N'(r);
        Neg  = ~neg;
    endtask

    task automatic wait_busy(input int start, output int cnt);
        cnt = start;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic observe_scan(output logic [6:0] s_sign, output logic [6:0] s_tens,
                                output logic [6:0] s_units, output int mask);
        s_sign  = 'x;
        s_tens  = 'x;
        s_units = 'x;
        mask    = 0;
        repeat (4 * (c_DIG + 1) * c_DIV) begin
            tick();
            case (an)
                3'b011: begin s_sign  = seg; mask |= 4; end
                3'b101: begin s_tens  = seg; mask |= 2; end
                3'b110: begin s_units = seg; mask |= 1; end
                default: mask |= 8;
            endcase
        end
    endtask

    task automatic test_reset();
        logic [2:0] exp_an [3];
        logic [6:0] exp_seg[3];
        exp_an[0] = 3'b101; exp_seg[0] = c_BLANK;
        exp_an[1] = 3'b011; exp_seg[1] = c_BLANK;
        exp_an[2] = 3'b110; exp_seg[2] = 7'b1000000;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++;
        if (an !== 3'b110) begin errors++; $display("FAIL reset_an: got %b exp 110", an); end
        checks++;
        if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b exp 1000000", seg); end
        rst = 1'b0;
        for (int p = 0; p < 3; p++) begin
            repeat (c_DIV) tick();
            checks++;
            if (an !== exp_an[p]) begin
                errors++; $display("FAIL scan_an[%0d]: got %b exp %b", p, an, exp_an[p]);
            end
            checks++;
            if (seg !== exp_seg[p]) begin
                errors++; $display("FAIL scan_seg[%0d]: got %b exp %b", p, seg, exp_seg[p]);
            end
        end
    endtask

    task automatic test_convert(input int r, input bit neg);
        int cnt, mask;
        logic [6:0] s, t, u;
        frame_t e;
        exp_q.push_back(model(r, neg));
        start_load(r, neg);
        wait_busy(0, cnt);
        checks++;
        if (cnt !== c_N + 1) begin
            errors++; $display("FAIL busy_len R=%0d: got %0d exp %0d", r, cnt, c_N + 1);
        end
        observe_scan(s, t, u, mask);
        e = exp_q.pop_front();
        checks++;
        if (mask !== 7) begin errors++; $display("FAIL scan_cover R=%0d: got %0d exp 7", r, mask); end
        checks++;
        if (s !== e.sgn) begin errors++; $display("FAIL sign R=%0d: got %b exp %b", r, s, e.sgn); end
        checks++;
        if (t !== e.tens) begin errors++; $display("FAIL tens R=%0d: got %b exp %b", r, t, e.tens); end
        checks++;
        if (u !== e.units) begin errors++; $display("FAIL units R=%0d: got %b exp %b", r, u, e.units); end
    endtask

    task automatic test_busy_ignore();
        int cnt, mask;
        logic [6:0] s, t, u;
        frame_t e;
        exp_q.push_back(model(12, 1'b0));
        start_load(12, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy_hi: got %b exp 1", busy); end
        load = 1'b1;
        R    = 4'd3;
        Neg  = 1'b0;
        tick();
        load = 1'b0;
        wait_busy(1, cnt);
        checks++;
        if (cnt !== c_N + 1) begin errors++; $display("FAIL ignore_busy_len: got %0d exp %0d", cnt, c_N + 1); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_requeue: got %b exp 0", busy); end
        observe_scan(s, t, u, mask);
        e = exp_q.pop_front();
        checks++;
        if (s !== e.sgn) begin errors++; $display("FAIL ignore_sign: got %b exp %b", s, e.sgn); end
        checks++;
        if (t !== e.tens) begin errors++; $display("FAIL ignore_tens: got %b exp %b", t, e.tens); end
        checks++;
        if (u !== e.units) begin errors++; $display("FAIL ignore_units: got %b exp %b", u, e.units); end
    endtask

    task automatic test_reset_abort();
        int mask;
        logic [6:0] s, t, u;
        frame_t e;
        exp_q.push_back(model(7, 1'b0));
        start_load(7, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy); end
        checks++;
        if (an !== 3'b110) begin errors++; $display("FAIL abort_an: got %b exp 110", an); end
        checks++;
        if (seg !== 7'b1000000) begin errors++; $display("FAIL abort_seg: got %b exp 1000000", seg); end
        exp_q.delete();
        exp_q.push_back(model(0, 1'b0));
        observe_scan(s, t, u, mask);
        e = exp_q.pop_front();
        checks++;
        if (s !== e.sgn) begin errors++; $display("FAIL abort_sign: got %b exp %b", s, e.sgn); end
        checks++;
        if (t !== e.tens) begin errors++; $display("FAIL abort_tens: got %b exp %b", t, e.tens); end
        checks++;
        if (u !== e.units) begin errors++; $display("FAIL abort_units: got %b exp %b", u, e.units); end
        test_convert(5, 1'b0);
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        R    = '0;
        Neg  = 1'b0;
        test_reset();
        test_convert(9, 1'b1);
        test_convert(15, 1'b0);
        test_convert(0, 1'b1);
        test_busy_ignore();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
